// File: rtl/ex_mem_skid_reg_if.sv
// Execute-to-memory handshake bundle: upstream valid/ready + instruction fields,
// downstream valid/ready + head entry fields, plus flush and status.
interface ex_mem_skid_reg_if #(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5
);
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] alu_result;
   logic              alu_zero;
   logic [DATA_W-1:0] rs2_data;
   logic [REG_AW-1:0] rd_addr;
   logic              reg_write;
   logic              mem_read;
   logic              mem_write;
   logic              branch;
   logic [DATA_W-1:0] branch_target;
   logic              flush;

   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_alu_result;
   logic [DATA_W-1:0] out_store_data;
   logic [DATA_W-1:0] out_branch_target;
   logic [REG_AW-1:0] out_rd_addr;
   logic              out_reg_write;
   logic              out_mem_read;
   logic              out_mem_write;
   logic              out_branch_taken;
   logic [1:0]        occupancy;
   logic              ctrl_err;

   // The pipeline register itself
   modport slave (
      input  in_valid, alu_result, alu_zero, rs2_data, rd_addr, reg_write,
             mem_read, mem_write, branch, branch_target, flush, out_ready,
      output in_ready, out_valid, out_alu_result, out_store_data,
             out_branch_target, out_rd_addr, out_reg_write, out_mem_read,
             out_mem_write, out_branch_taken, occupancy, ctrl_err
   );

   // Execute/memory side that drives and consumes the register
   modport master (
      output in_valid, alu_result, alu_zero, rs2_data, rd_addr, reg_write,
             mem_read, mem_write, branch, branch_target, flush, out_ready,
      input  in_ready, out_valid, out_alu_result, out_store_data,
             out_branch_target, out_rd_addr, out_reg_write, out_mem_read,
             out_mem_write, out_branch_taken, occupancy, ctrl_err
   );
endinterface

// File: rtl/ex_mem_skid_reg.sv
// EX/MEM pipeline register with a two-entry skid buffer (head drives outputs).
// Branch resolution and control sanitising happen at capture time.
module ex_mem_skid_reg #(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5
) (
   input  logic               clk,
   input  logic               reset,
   ex_mem_skid_reg_if.slave   bus
);

   typedef struct packed {
      logic [DATA_W-1:0] alu_result;
      logic [DATA_W-1:0] store_data;
      logic [DATA_W-1:0] branch_target;
      logic [REG_AW-1:0] rd_addr;
      logic              reg_write;
      logic              mem_read;
      logic              mem_write;
      logic              branch_taken;
   } entry_t;

   entry_t head_reg;
   entry_t skid_reg;
   entry_t cap_entry;
   logic   head_valid_reg;
   logic   skid_valid_reg;
   logic   ctrl_err_reg;
   logic   accept;
   logic   pop;
   logic   bad_ctrl;

   // in_ready comes only from registered state, never from out_ready
   assign bus.in_ready = ~skid_valid_reg & ~reset;
   assign accept       = bus.in_valid & bus.in_ready;
   assign pop          = head_valid_reg & bus.out_ready;
   assign bad_ctrl     = bus.mem_read & bus.mem_write;

   always_comb begin
      cap_entry               = '0;
      cap_entry.alu_result    = bus.alu_result;
      cap_entry.store_data    = bus.rs2_data;
      cap_entry.branch_target = bus.branch_target;
      cap_entry.rd_addr       = bus.rd_addr;
      cap_entry.reg_write     = bus.reg_write & (bus.rd_addr != '0);
      cap_entry.mem_read      = bus.mem_read;
      cap_entry.mem_write     = bus.mem_write & ~bus.mem_read;
      cap_entry.branch_taken  = bus.branch & bus.alu_zero;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         head_reg       <= '0;
         skid_reg       <= '0;
         head_valid_reg <= 1'b0;
         skid_valid_reg <= 1'b0;
         ctrl_err_reg   <= 1'b0;
      end else if (bus.flush) begin
         // A same-cycle pop has already been taken by the consumer; just drop everything
         head_valid_reg <= 1'b0;
         skid_valid_reg <= 1'b0;
      end else begin
         if (accept && bad_ctrl) begin
            ctrl_err_reg <= 1'b1;
         end
         if (skid_valid_reg) begin
            if (pop) begin
               head_reg       <= skid_reg;
               skid_valid_reg <= 1'b0;
            end
         end else if (head_valid_reg) begin
            if (pop) begin
               if (accept) begin
                  head_reg <= cap_entry;
               end else begin
                  head_valid_reg <= 1'b0;
               end
            end else if (accept) begin
               skid_reg       <= cap_entry;
               skid_valid_reg <= 1'b1;
            end
         end else if (accept) begin
            head_reg       <= cap_entry;
            head_valid_reg <= 1'b1;
         end
      end
   end

   assign bus.out_valid         = head_valid_reg;
   assign bus.out_alu_result    = head_reg.alu_result;
   assign bus.out_store_data    = head_reg.store_data;
   assign bus.out_branch_target = head_reg.branch_target;
   assign bus.out_rd_addr       = head_reg.rd_addr;
   assign bus.out_reg_write     = head_reg.reg_write;
   assign bus.out_mem_read      = head_reg.mem_read;
   assign bus.out_mem_write     = head_reg.mem_write;
   assign bus.out_branch_taken  = head_reg.branch_taken;
   assign bus.occupancy         = {1'b0, head_valid_reg} + {1'b0, skid_valid_reg};
   assign bus.ctrl_err          = ctrl_err_reg;

endmodule

// File: doc/ex_mem_skid_reg.md
# ex_mem_skid_reg

Execute-to-memory pipeline register placed directly downstream of the 32-bit ALU array. It captures the ALU result and zero flag together with the instruction's control and store data, resolves the branch condition, and presents one entry per cycle to the memory stage. A two-entry skid buffer with a valid/ready handshake lets the memory stage stall without dropping a result already produced by the ALU.

## Interface
- DATA_W, 32, width of ALU result, store data and branch target
- REG_AW, 5, destination register address width
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  execute stage presents a completed instruction
- in_ready  out  1  register can accept this cycle
- alu_result  in  DATA_W  ALU Result
- alu_zero  in  1  ALU Zero flag
- rs2_data  in  DATA_W  store data
- rd_addr  in  REG_AW  destination register
- reg_write, mem_read, mem_write, branch  in  1 each  decoded control
- branch_target  in  DATA_W  precomputed PC+imm
- flush  in  1  discard all held and incoming entries
- out_valid  out  1  head entry valid
- out_ready  in  1  memory stage consumes head
- out_alu_result, out_store_data, out_branch_target  out  DATA_W  head entry fields
- out_rd_addr  out  REG_AW; out_reg_write, out_mem_read, out_mem_write, out_branch_taken  out  1 each
- occupancy  out  2  entries held (0..2)
- ctrl_err  out  1  sticky: accepted entry had mem_read and mem_write both set

## Operation
- Storage: head register (drives outputs) and skid register. in_ready = ~skid_valid & ~reset.
- Accept = in_valid & in_ready. Pop = out_valid & out_ready.
- At capture: branch_taken = branch & alu_zero. reg_write forced 0 when rd_addr == 0. If mem_read & mem_write, store mem_read=1, mem_write=0 and set ctrl_err.
- Empty + accept: entry goes to head. Head valid, no pop, accept: entry goes to skid. Head valid, pop, accept, skid empty: new entry replaces head. Pop with skid valid: skid moves to head, skid cleared. Accept is never possible while skid is valid.
- Entries leave strictly in arrival order. No entry is duplicated or lost.
- occupancy = head_valid + skid_valid and never exceeds 2.
- flush: both entries invalidated at the next edge. An accept in the same cycle is discarded. A pop in the same cycle still completes because the output was valid. flush does not clear ctrl_err.
- reset: head_valid, skid_valid and ctrl_err cleared. All out_* data and control registers cleared to 0.

## Timing
- Reset values: out_valid 0, all out_* 0, occupancy 0, ctrl_err 0, in_ready 0 while reset is high and 1 in the first cycle after.
- Latency: accept at edge N gives out_valid=1 with that entry's fields after edge N, i.e. visible in cycle N+1.
- Throughput is 1 entry/cycle while out_ready stays high. in_ready depends only on registered state and reset, with no combinational path from out_ready.
- A stall of 1 cycle (out_ready low) absorbs at most 1 extra entry. in_ready drops the cycle after skid fills and rises the cycle after the skid drains into head.
- Reset asserted mid-stream takes priority over accept, pop and flush at the same edge.

## Test plan
- Single pass: reset, then accept alu_result=0x0000_0010, rd=5, reg_write=1 -> next cycle out_valid=1, out_alu_result=0x10, out_rd_addr=5, occupancy=1; pop -> occupancy 0.
- Branch resolution: branch=1, alu_zero=1, branch_target=0x100 -> out_branch_taken=1, out_branch_target=0x100; repeat with alu_zero=0 -> out_branch_taken=0.
- Back-pressure: stream results 1,2,3,4 with out_ready low for 2 cycles after the first accept -> occupancy reaches 2, in_ready falls, 3 is held until space frees; output order is exactly 1,2,3,4 with none lost.
- x0 and control error: rd_addr=0, reg_write=1 -> out_reg_write=0. mem_read=mem_write=1 -> out_mem_read=1, out_mem_write=0, ctrl_err stays 1 until reset.
- Flush: occupancy=2 and flush=1 with in_valid=1 -> next cycle out_valid=0, occupancy=0, incoming entry never appears.
- Reset mid-stream: occupancy=2, assert reset for 1 cycle -> all outputs 0, in_ready 0 during reset and 1 the cycle after.
